// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin request/grant arbiter and SCL/SDA multiplexer
// for N_CH I2C engines sharing one open-drain bus pair. A grant is only ever
// issued after a bus-free interval of IDLE_CYCLES with both lines released.
// Optional owner hold limit: define I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
   parameter int unsigned N_CH           = 2,
   parameter int unsigned IDLE_CYCLES    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] req,
   input  logic [N_CH-1:0] ch_sclk,
   input  logic [N_CH-1:0] ch_sdat,
   output logic [N_CH-1:0] grant,
   output logic            busy,
   output logic            i2c_sclk,
   output logic            i2c_sdat,
   output logic            timeout
);

   localparam int unsigned IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned ICNT_W = $clog2(IDLE_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_OWN     = 2'd1,
      S_RELEASE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic [ICNT_W-1:0]  icnt_q, icnt_d;
   logic [N_CH-1:0]    grant_q, grant_d;
   logic               busy_q, busy_d;
   logic               sclk_q, sclk_d;
   logic               sdat_q, sdat_d;

   logic [N_CH-1:0]    elig_c;
   logic               found_c;
   logic [IDX_W-1:0]   win_c;
   logic [IDX_W-1:0]   idx_c;
   logic               hold_expired_c;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
   logic [N_CH-1:0]    mask_q, mask_d;
   logic               timeout_q, timeout_d;

   // A hung owner is cut off after TIMEOUT_CYCLES cycles of continuous ownership.
   always_comb begin
      hold_expired_c = (32'(tcnt_q) == (TIMEOUT_CYCLES - 32'd1));
      elig_c         = req & ~mask_q;
   end

   // Hold-limit counter, channel mask and timeout pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt_q    <= '0;
         mask_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         tcnt_q    <= tcnt_d;
         mask_q    <= mask_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   // Without the hold limit every requester is always eligible.
   always_comb begin
      hold_expired_c = 1'b0;
      elig_c         = req;
   end

   assign timeout = 1'b0;
`endif

   // Round-robin pick: first eligible channel scanning upward from rr_q.
   always_comb begin
      found_c = 1'b0;
      win_c   = '0;
      idx_c   = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         idx_c = IDX_W'((32'(rr_q) + k) % N_CH);
         if (!found_c && elig_c[idx_c]) begin
            found_c = 1'b1;
            win_c   = idx_c;
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      icnt_d  = icnt_q;
      grant_d = grant_q;
      busy_d  = busy_q;
      sclk_d  = sclk_q;
      sdat_d  = sdat_q;
`ifdef I2C_ARB_TIMEOUT_EN
      tcnt_d    = tcnt_q;
      mask_d    = mask_q & req;
      timeout_d = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            sclk_d = 1'b1;
            sdat_d = 1'b1;
            if (found_c) begin
               grant_d        = '0;
               grant_d[win_c] = 1'b1;
               busy_d         = 1'b1;
               owner_d        = win_c;
               state_d        = S_OWN;
`ifdef I2C_ARB_TIMEOUT_EN
               tcnt_d = '0;
`endif
            end
         end

         S_OWN: begin
            if (!req[owner_q] || hold_expired_c) begin
               grant_d = '0;
               sclk_d  = 1'b1;
               sdat_d  = 1'b1;
               rr_d    = IDX_W'((32'(owner_q) + 32'd1) % N_CH);
               icnt_d  = '0;
               state_d = S_RELEASE;
`ifdef I2C_ARB_TIMEOUT_EN
               if (req[owner_q]) begin
                  timeout_d       = 1'b1;
                  mask_d[owner_q] = 1'b1;
               end
`endif
            end else begin
               sclk_d = ch_sclk[owner_q];
               sdat_d = ch_sdat[owner_q];
`ifdef I2C_ARB_TIMEOUT_EN
               tcnt_d = tcnt_q + TCNT_W'(1);
`endif
            end
         end

         S_RELEASE: begin
            sclk_d = 1'b1;
            sdat_d = 1'b1;
            icnt_d = icnt_q + ICNT_W'(1);
            if ((32'(icnt_q) + 32'd1) >= (IDLE_CYCLES - 32'd1)) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            sclk_d  = 1'b1;
            sdat_d  = 1'b1;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         rr_q    <= '0;
         icnt_q  <= '0;
         grant_q <= '0;
         busy_q  <= 1'b0;
         sclk_q  <= 1'b1;
         sdat_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         icnt_q  <= icnt_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         sclk_q  <= sclk_d;
         sdat_q  <= sdat_d;
      end
   end

   assign grant    = grant_q;
   assign busy     = busy_q;
   assign i2c_sclk = sclk_q;
   assign i2c_sdat = sdat_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: a 4-channel instance checked every
// cycle against a reference model, plus a 1-channel instance with directed checks.
module tb_i2c_bus_arbiter;

   localparam int unsigned N    = 4;
   localparam int unsigned IDLE = 4;
   localparam int unsigned TO   = 100;
`ifdef I2C_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   // Edges from the releasing edge to the edge on which busy falls.
   localparam int GAP = (IDLE > 1) ? int'(IDLE) - 1 : 1;

   typedef struct packed {
      logic [3:0] grant;
      logic       busy;
      logic       sclk;
      logic       sdat;
      logic       tmo;
   } exp_t;

   logic       clk, rst_n;
   logic [3:0] req, ch_sclk, ch_sdat, grant;
   logic       busy, i2c_sclk, i2c_sdat, timeout;
   logic       req1, sclk1, sdat1, grant1, busy1, isclk1, isdat1, tmo1;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   exp_t exp_q[$];
   int   tag_q[$];

   // Reference model state
   int         m_owner, m_grant_cyc, m_rel_cyc, m_rr;
   bit         m_rel;
   logic [3:0] m_mask;

   // Monitor bookkeeping
   logic [3:0] gq[$];
   logic [3:0] prev_g = '0;
   bit         rr_on = 0, b_on = 0, n1_on = 0;
   int         tmo_cnt = 0, b_grants = 0;
   int         n1_grants = 0, n1_bad = 0, n1_min_gap = 1000, gap1 = 0;
   bit         n1_seen = 0;
   logic       g1_prev = 1'b0;

   i2c_bus_arbiter #(.N_CH(N), .IDLE_CYCLES(IDLE), .TIMEOUT_CYCLES(TO)) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .ch_sclk(ch_sclk), .ch_sdat(ch_sdat),
      .grant(grant), .busy(busy), .i2c_sclk(i2c_sclk), .i2c_sdat(i2c_sdat),
      .timeout(timeout)
   );

   i2c_bus_arbiter #(.N_CH(1), .IDLE_CYCLES(IDLE), .TIMEOUT_CYCLES(TO)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req(req1), .ch_sclk(sclk1), .ch_sdat(sdat1),
      .grant(grant1), .busy(busy1), .i2c_sclk(isclk1), .i2c_sdat(isdat1),
      .timeout(tmo1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_grant_cyc = 0; m_rel_cyc = 0; m_rr = 0; m_rel = 0; m_mask = '0;
   endtask

   task automatic release_bus(input int t);
      m_rr    = (m_owner + 1) % int'(N);
      m_owner = -1;
      m_rel   = 1;
      m_rel_cyc = t;
   endtask

   // Expected outputs after edge t, given the inputs sampled at that edge.
   task automatic model_step(input logic [3:0] r, input logic [3:0] s, input logic [3:0] d,
                             input int t, output exp_t e);
      int to_bit;
      to_bit = -1;
      e = '0;
      e.sclk = 1'b1;
      e.sdat = 1'b1;
      if (m_owner >= 0) begin
         e.busy = 1'b1;
         if (!r[m_owner]) begin
            release_bus(t);
         end else if (TO_EN && (t - m_grant_cyc == int'(TO))) begin
            to_bit = m_owner;
            e.tmo  = 1'b1;
            release_bus(t);
         end else begin
            e.grant[m_owner] = 1'b1;
            e.sclk = s[m_owner];
            e.sdat = d[m_owner];
         end
      end else if (m_rel) begin
         if (t - m_rel_cyc >= GAP) m_rel = 0;
         else e.busy = 1'b1;
      end else begin
         for (int k = 0; k < int'(N); k++) begin
            int idx;
            idx = (m_rr + k) % int'(N);
            if (m_owner < 0 && r[idx] && !m_mask[idx]) begin
               m_owner = idx;
               m_grant_cyc = t;
            end
         end
         if (m_owner >= 0) begin
            e.grant[m_owner] = 1'b1;
            e.busy = 1'b1;
         end
      end
      m_mask = m_mask & r;
      if (to_bit >= 0) m_mask[to_bit] = 1'b1;
   endtask

   // Drive one cycle of inputs and queue the response expected after the next edge.
   task automatic cycle(input logic [3:0] r, input logic [3:0] s, input logic [3:0] d);
      exp_t e;
      req = r; ch_sclk = s; ch_sdat = d;
      model_step(r, s, d, cyc + 1, e);
      exp_q.push_back(e);
      tag_q.push_back(cyc + 1);
      @(posedge clk); #1;
   endtask

   // Scoreboard monitor for the 4-channel instance.
   initial forever begin
      exp_t e;
      exp_t act;
      int   t;
      @(posedge clk); #3;
      while (tag_q.size() > 0 && tag_q[0] <= cyc) begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         act = {grant, busy, i2c_sclk, i2c_sdat, timeout};
         check($sformatf("bus@%0d {grant,busy,scl,sda,tmo}", t), 32'(act), 32'(e));
      end
      if (rr_on && grant != 4'h0 && prev_g == 4'h0) gq.push_back(grant);
      if (b_on && grant[0] && !prev_g[0]) b_grants++;
      if (b_on && timeout) tmo_cnt++;
      prev_g = grant;
   end

   // Directed monitor for the single-channel instance.
   initial forever begin
      @(posedge clk); #3;
      if (n1_on) begin
         if (grant1 && !g1_prev) begin
            n1_grants++;
            if (n1_seen && gap1 < n1_min_gap) n1_min_gap = gap1;
            n1_seen = 1;
         end
         if (!grant1) begin
            gap1++;
            if (!(isclk1 && isdat1)) n1_bad++;
         end else begin
            gap1 = 0;
         end
         if (!busy1 && grant1) n1_bad++;
         g1_prev = grant1;
      end
   end

   initial begin
      logic [3:0] exp_order [5];
      logic [3:0] r;
      exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
      exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;

      model_reset();
      rst_n = 1'b0; req = 4'hF; ch_sclk = 4'h0; ch_sdat = 4'h0;
      req1 = 1'b0; sclk1 = 1'b0; sdat1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset grant", 32'(grant), 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      check("reset scl", 32'(i2c_sclk), 32'h1);
      check("reset sda", 32'(i2c_sdat), 32'h1);
      check("reset timeout", 32'(timeout), 32'h0);
      rst_n = 1'b1;
      model_reset();

      // Round-robin: all request, each owner drops req for one cycle after 20 cycles.
      rr_on = 1;
      for (int i = 0; i < 300 && gq.size() < 5; i++) begin
         r = 4'hF;
         if (m_owner >= 0 && (cyc + 1 - m_grant_cyc) >= 20) r[m_owner] = 1'b0;
         cycle(r, 4'($urandom), 4'($urandom));
      end
      rr_on = 0;
      for (int k = 0; k < 5; k++)
         check($sformatf("rr_order[%0d]", k), (k < gq.size()) ? 32'(gq[k]) : 32'h0,
               32'(exp_order[k]));

      // Channel 0 holds req; with the hold limit it is revoked and masked.
      for (int i = 0; i < 10; i++) cycle(4'h0, 4'($urandom), 4'($urandom));
      b_on = 1;
      for (int i = 0; i < 150; i++) cycle(4'h1, 4'($urandom), 4'($urandom));
      cycle(4'h0, 4'($urandom), 4'($urandom));
      for (int i = 0; i < 25; i++) cycle(4'h1, 4'($urandom), 4'($urandom));
      for (int i = 0; i < 10; i++) cycle(4'h0, 4'($urandom), 4'($urandom));
      b_on = 0;
      check("ch0 grants", 32'(b_grants), 32'd2);
      check("timeout pulses", 32'(tmo_cnt), TO_EN ? 32'd1 : 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         r = req;
         for (int c = 0; c < int'(N); c++) begin
            if (c == m_owner) begin
               if ($urandom_range(19) == 0) r[c] = 1'b0;
            end else if ($urandom_range(5) == 0) begin
               r[c] = ~r[c];
            end
         end
         cycle(r, 4'($urandom), 4'($urandom));
      end

      // Single-channel instance: three request pulses with short drops.
      for (int i = 0; i < 10; i++) cycle(4'h0, 4'($urandom), 4'($urandom));
      n1_on = 1;
      for (int p = 0; p < 3; p++) begin
         req1 = 1'b1;
         for (int i = 0; i < 10; i++) cycle(4'h0, 4'($urandom), 4'($urandom));
         req1 = 1'b0;
         cycle(4'h0, 4'($urandom), 4'($urandom));
      end
      for (int i = 0; i < 12; i++) cycle(4'h0, 4'($urandom), 4'($urandom));
      n1_on = 0;
      check("n1 grants", 32'(n1_grants), 32'd3);
      check("n1 gap >= IDLE_CYCLES", 32'(n1_min_gap >= int'(IDLE)), 32'd1);
      check("n1 idle-line/invariant violations", 32'(n1_bad), 32'd0);

      // Asynchronous reset while channel 2 owns the bus with both lines low.
      for (int i = 0; i < 5; i++) cycle(4'b0100, 4'h0, 4'h0);
      #3;
      check("pre-reset scl low", 32'(i2c_sclk), 32'h0);
      rst_n = 1'b0;
      #1;
      check("async reset grant", 32'(grant), 32'h0);
      check("async reset busy", 32'(busy), 32'h0);
      check("async reset scl", 32'(i2c_sclk), 32'h1);
      check("async reset sda", 32'(i2c_sdat), 32'h1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      req = 4'h0;
      for (int i = 0; i < 100; i++) begin
         r = req;
         for (int c = 0; c < int'(N); c++)
            if ($urandom_range(7) == 0) r[c] = ~r[c];
         cycle(r, 4'($urandom), 4'($urandom));
      end

      #5;
      check("scoreboard drained", 32'(tag_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
